// File: rtl/block_mac_2x2_if.sv
`default_nettype none
// ============================================================================
// Module   : block_mac_2x2_if
// Purpose  : Operand/result bundle between the matrix control unit (master)
//            and the 2x2 block multiplier (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface block_mac_2x2_if #(
  parameter int DATA_W = 32
);
  logic                     start_mac;
  logic signed [DATA_W-1:0] a_11, a_12, a_21, a_22;
  logic signed [DATA_W-1:0] b_11, b_12, b_21, b_22;
  logic signed [DATA_W-1:0] c_11, c_12, c_21, c_22;
  logic                     done_mac;
  logic                     busy;
  logic                     ovf;

  modport master (
    output start_mac, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    input  c_11, c_12, c_21, c_22, done_mac, busy, ovf
  );

  modport slave (
    input  start_mac, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    output c_11, c_12, c_21, c_22, done_mac, busy, ovf
  );
endinterface
`default_nettype wire

// File: rtl/block_mac_2x2.sv
`default_nettype none
// ============================================================================
// Module   : block_mac_2x2
// Purpose  : Sequential 2x2 block multiply C = A x B using one time-shared
//            pipelined signed multiplier and four accumulators. Latency from
//            the accept edge to done_mac is MUL_LAT+10 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module block_mac_2x2 #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  block_mac_2x2_if.slave bus
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  logic   start_d;
  logic   accept;
  logic [2:0] idx;

  // Operand copies, index = row*2 + col (0:x11 1:x12 2:x21 3:x22)
  logic signed [DATA_W-1:0] op_a [4];
  logic signed [DATA_W-1:0] op_b [4];
  logic signed [DATA_W-1:0] acc  [4];
  logic signed [DATA_W-1:0] c_q  [4];
  logic done_q, busy_q, ovf_q, last_seen;

  // Issue register feeding the multiplier
  logic                     iss_valid, iss_last;
  logic [1:0]               iss_tgt;
  logic signed [DATA_W-1:0] iss_a, iss_b;
  logic signed [DATA_W-1:0] sel_a, sel_b;

  // Multiplier pipeline
  logic signed [PW-1:0] prod_pipe [MUL_LAT];
  logic [1:0]           tgt_pipe  [MUL_LAT];
  logic [MUL_LAT-1:0]   vld_pipe, last_pipe;

  // Accumulate-stage signals
  logic signed [PW-1:0]     p_out;
  logic signed [DATA_W-1:0] p_lo, acc_cur, acc_sum;
  logic [1:0]               p_tgt;
  logic                     p_fit, add_ovf;

  assign accept = bus.start_mac & ~start_d & (state == IDLE);

  // Product selection: A element (row idx[2], col idx[0]) times B element (row idx[0], col idx[1])
  always_comb begin
    sel_a = op_a[{idx[2], idx[0]}];
    sel_b = op_b[{idx[0], idx[1]}];
  end

  // Multiplier pipeline: stage 0 forms the full-width signed product, later stages delay it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= iss_valid;
      last_pipe[0] <= iss_last;
      for (int s = 1; s < MUL_LAT; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        last_pipe[s] <= last_pipe[s-1];
      end
    end
    prod_pipe[0] <= PW'(iss_a) * PW'(iss_b);
    tgt_pipe[0]  <= iss_tgt;
    for (int s = 1; s < MUL_LAT; s++) begin
      prod_pipe[s] <= prod_pipe[s-1];
      tgt_pipe[s]  <= tgt_pipe[s-1];
    end
  end

  // Accumulate stage: truncated product, wrap-around sum and both overflow conditions
  always_comb begin
    p_out   = prod_pipe[MUL_LAT-1];
    p_tgt   = tgt_pipe[MUL_LAT-1];
    p_lo    = p_out[DATA_W-1:0];
    acc_cur = acc[p_tgt];
    acc_sum = acc_cur + p_lo;
    p_fit   = (p_out[PW-1:DATA_W-1] == {(DATA_W+1){p_out[DATA_W-1]}});
    add_ovf = (acc_cur[DATA_W-1] == p_lo[DATA_W-1]) &&
              (acc_sum[DATA_W-1] != acc_cur[DATA_W-1]);
  end

  // Control FSM with operand latching, issue, accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      idx       <= 3'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      last_seen <= 1'b0;
      iss_valid <= 1'b0;
      iss_last  <= 1'b0;
      iss_tgt   <= 2'd0;
      iss_a     <= '0;
      iss_b     <= '0;
      for (int i = 0; i < 4; i++) begin
        op_a[i] <= '0;
        op_b[i] <= '0;
        acc[i]  <= '0;
        c_q[i]  <= '0;
      end
    end else begin
      start_d   <= bus.start_mac;
      done_q    <= 1'b0;
      iss_valid <= 1'b0;
      iss_last  <= 1'b0;

      if (vld_pipe[MUL_LAT-1]) begin
        acc[p_tgt] <= acc_sum;
        if (!p_fit || add_ovf) ovf_q <= 1'b1;
        if (last_pipe[MUL_LAT-1]) last_seen <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state     <= ISSUE;
            idx       <= 3'd0;
            busy_q    <= 1'b1;
            ovf_q     <= 1'b0;
            last_seen <= 1'b0;
            op_a[0] <= bus.a_11;  op_a[1] <= bus.a_12;
            op_a[2] <= bus.a_21;  op_a[3] <= bus.a_22;
            op_b[0] <= bus.b_11;  op_b[1] <= bus.b_12;
            op_b[2] <= bus.b_21;  op_b[3] <= bus.b_22;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
          end
        end
        ISSUE: begin
          iss_valid <= 1'b1;
          iss_last  <= (idx == 3'd7);
          iss_tgt   <= idx[2:1];
          iss_a     <= sel_a;
          iss_b     <= sel_b;
          idx       <= idx + 3'd1;
          if (idx == 3'd7) state <= DRAIN;
        end
        DRAIN: begin
          if (last_seen) begin
            state  <= DONE;
            done_q <= 1'b1;
            for (int i = 0; i < 4; i++) c_q[i] <= acc[i];
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.c_11     = c_q[0];
  assign bus.c_12     = c_q[1];
  assign bus.c_21     = c_q[2];
  assign bus.c_22     = c_q[3];
  assign bus.done_mac = done_q;
  assign bus.busy     = busy_q;
  assign bus.ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_block_mac_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_mac_2x2
// Purpose  : Self-checking bench for block_mac_2x2 at MUL_LAT = 2, 1 and 8,
//            all three instances driven with identical stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_mac_2x2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_mac = 1'b0;
  logic [3:0][31:0] op_a = '0;
  logic [3:0][31:0] op_b = '0;

  logic [3:0][31:0] c_v [3];
  logic [2:0] done_v, busy_v, ovf_v;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-operation observations
  logic [3:0][31:0] r_c [3];
  logic r_ovf [3];
  int   r_lat [3];
  int   r_cnt [3];
  int   busy_bad;
  int   hold_bad;

  localparam longint MAXV = 64'sh7FFFFFFF;
  localparam longint MINV = -64'sh80000000;

  // Free-running clock
  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      block_mac_2x2_if #(.DATA_W(32)) bus ();
      assign bus.start_mac = start_mac;
      assign bus.a_11 = op_a[0];
      assign bus.a_12 = op_a[1];
      assign bus.a_21 = op_a[2];
      assign bus.a_22 = op_a[3];
      assign bus.b_11 = op_b[0];
      assign bus.b_12 = op_b[1];
      assign bus.b_21 = op_b[2];
      assign bus.b_22 = op_b[3];
      assign c_v[g]    = {bus.c_22, bus.c_21, bus.c_12, bus.c_11};
      assign done_v[g] = bus.done_mac;
      assign busy_v[g] = bus.busy;
      assign ovf_v[g]  = bus.ovf;
      block_mac_2x2 #(
        .DATA_W (32),
        .MUL_LAT((g == 0) ? 2 : (g == 1) ? 1 : 8)
      ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
      );
    end
  endgenerate

  function automatic int lat_of(input int g);
    return (g == 0) ? 12 : (g == 1) ? 11 : 18;
  endfunction

  function automatic logic [3:0][31:0] mk4(input logic [31:0] x11, x12, x21, x22);
    return {x22, x21, x12, x11};
  endfunction

  // Reference 2x2 product using 64-bit arithmetic and range checks
  function automatic void ref_mac(input logic [3:0][31:0] a, b,
                                  output logic [3:0][31:0] c, output logic o);
    longint p, s;
    logic [31:0] acc;
    o = 1'b0;
    c = '0;
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < 2; q++) begin
        acc = '0;
        for (int k = 0; k < 2; k++) begin
          p = longint'($signed(a[r*2+k])) * longint'($signed(b[k*2+q]));
          if (p > MAXV || p < MINV) o = 1'b1;
          s = longint'($signed(acc)) + longint'($signed(p[31:0]));
          if (s > MAXV || s < MINV) o = 1'b1;
          acc = s[31:0];
        end
        c[r*2+q] = acc;
      end
    end
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One operation: accept at the next edge, observe 30 cycles on the falling edge
  task automatic run_op(input logic [3:0][31:0] a, b, input int hold, input int re_k);
    logic [3:0][31:0] prev;
    @(negedge clk);
    op_a = a;
    op_b = b;
    start_mac = 1'b1;
    prev = c_v[0];
    busy_bad = 0;
    hold_bad = 0;
    for (int g = 0; g < 3; g++) begin
      r_lat[g] = -1;
      r_cnt[g] = 0;
      r_c[g]   = '0;
      r_ovf[g] = 1'b0;
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        op_a = {$urandom, $urandom, $urandom, $urandom};
        op_b = {$urandom, $urandom, $urandom, $urandom};
      end
      if (k + 1 >= hold) start_mac = 1'b0;
      if (k == re_k) start_mac = 1'b1;
      for (int g = 0; g < 3; g++) begin
        if (done_v[g]) begin
          r_cnt[g]++;
          if (r_lat[g] < 0) begin
            r_lat[g] = k;
            r_c[g]   = c_v[g];
            r_ovf[g] = ovf_v[g];
          end
        end
      end
      if ((k <= 12) != busy_v[0]) busy_bad++;
      if (k < 12 && c_v[0] !== prev) hold_bad++;
      if (k > 12 && c_v[0] !== r_c[0]) hold_bad++;
    end
    start_mac = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [3:0][31:0] ce, input logic oe);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s c dut%0d", nm, g), 128'(r_c[g]), 128'(ce));
      check($sformatf("%s ovf dut%0d", nm, g), 128'(r_ovf[g]), 128'(oe));
      check($sformatf("%s latency dut%0d", nm, g), 128'(r_lat[g]), 128'(lat_of(g)));
      check($sformatf("%s done count dut%0d", nm, g), 128'(r_cnt[g]), 128'(1));
    end
    check($sformatf("%s busy window", nm), 128'(busy_bad), 128'(0));
    check($sformatf("%s c hold", nm), 128'(hold_bad), 128'(0));
  endtask

  typedef struct {
    string            name;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [3:0][31:0] c;
    logic             o;
  } vec_t;

  vec_t vecs [8];

  // Main test sequence
  initial begin
    int cnt;

    vecs[0] = '{"basic",   mk4(1, 2, 3, 4), mk4(5, 6, 7, 8), mk4(19, 22, 43, 50), 1'b0};
    vecs[1] = '{"signed",  mk4(-1, 0, 0, -1), mk4(5, -6, 7, 8), mk4(-5, 6, -7, -8), 1'b0};
    vecs[2] = '{"prodovf", mk4(32'h7FFFFFFF, 0, 0, 0), mk4(2, 0, 0, 0),
                mk4(32'hFFFFFFFE, 0, 0, 0), 1'b1};
    vecs[3] = '{"clean",   mk4(1, 2, 3, 4), mk4(5, 6, 7, 8), mk4(19, 22, 43, 50), 1'b0};
    vecs[4] = '{"accovf",  mk4(32'h40000000, 32'h40000000, 0, 0), mk4(1, 0, 1, 0),
                mk4(32'h80000000, 0, 0, 0), 1'b1};
    vecs[5] = '{"minfit",  mk4(32'h80000000, 0, 0, 0), mk4(1, 0, 0, 0),
                mk4(32'h80000000, 0, 0, 0), 1'b0};
    vecs[6] = '{"minneg",  mk4(32'h80000000, 0, 0, 0), mk4(-1, 0, 0, 0),
                mk4(32'h80000000, 0, 0, 0), 1'b1};
    vecs[7] = '{"mixed",   mk4(-3, 4, 5, -6), mk4(7, -8, -9, 10), mk4(-57, 64, 89, -100), 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset c dut%0d", g), 128'(c_v[g]), 128'(0));
      check($sformatf("reset flags dut%0d", g),
            128'({done_v[g], busy_v[g], ovf_v[g]}), 128'(0));
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1, -1);
      check_op(vecs[i].name, vecs[i].c, vecs[i].o);
    end

    // Start held three cycles plus a second rising edge during ISSUE
    run_op(mk4(1, 2, 3, 4), mk4(5, 6, 7, 8), 3, 5);
    check_op("start_hold", mk4(19, 22, 43, 50), 1'b0);
    run_op(mk4(-1, 0, 0, -1), mk4(5, -6, 7, 8), 1, -1);
    check_op("start_again", mk4(-5, 6, -7, -8), 1'b0);

    // Reset in the middle of ISSUE (idx 4)
    @(negedge clk);
    op_a = mk4(1, 2, 3, 4);
    op_b = mk4(5, 6, 7, 8);
    start_mac = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start_mac = 1'b0;
      if (k == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("midrst c dut%0d", g), 128'(c_v[g]), 128'(0));
      check($sformatf("midrst flags dut%0d", g),
            128'({done_v[g], busy_v[g], ovf_v[g]}), 128'(0));
    end
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) if (done_v[g]) cnt++;
    end
    check("midrst no done", 128'(cnt), 128'(0));
    run_op(mk4(1, 2, 3, 4), mk4(5, 6, 7, 8), 1, -1);
    check_op("after_rst", mk4(19, 22, 43, 50), 1'b0);

    // Randomised operands against the reference model
    for (int i = 0; i < 6; i++) begin
      logic [3:0][31:0] ra, rb, rc;
      logic ro;
      for (int j = 0; j < 4; j++) begin
        if (i < 3) begin
          ra[j] = 32'($urandom_range(0, 2000)) - 32'd1000;
          rb[j] = 32'($urandom_range(0, 2000)) - 32'd1000;
        end else begin
          ra[j] = $urandom;
          rb[j] = $urandom;
        end
      end
      ref_mac(ra, rb, rc, ro);
      run_op(ra, rb, 1, -1);
      check_op($sformatf("rand%0d", i), rc, ro);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
